uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts one byte on a valid/ready handshake and shifts it
// out LSB first, with each bit held for CLKS_PER_BIT clock cycles.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TXD
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             bit_done;

  assign bit_done = (cnt_q == CNT_LAST);
  assign tx_ready = ready_q;
  assign TXD      = txd_q;

  // NOTE: every *_d gets a default before the case, so no path leaves a signal
  // unassigned and no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    ready_d = ready_q;

    unique case (state_q)
      IDLE: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          state_d = START;
          txd_d   = 1'b0;
          ready_d = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            // The next bit to send is bit 1 of the current shift value.
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = IDLE;
          ready_d = 1'b1;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see
  // the pre-edge values of each other, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
    end
  end

endmodule
